// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver state encoding and
// the clock divider helper used to derive the oversampling tick rate.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Clocks per oversampling tick, truncated; never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud * oversample);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick pulse every DIV clocks.
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   clear restarts the count so the next tick lands DIV clocks later
//   tick  single-cycle pulse
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output slot.
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   rxd               asynchronous serial input, idle high
//   rx_data           received character (first line bit in LSB)
//   rx_valid/rx_ready output handshake; slot holds until accepted
//   parity_err        parity mismatch for the presented character
//   frame_err         a stop bit was sampled low for the presented character
//   overrun           sticky; a completed character found the slot full
//   rx_busy           high from confirmed start bit until back in IDLE
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic sync_1, sync_2, line_prev;
    logic line, fall;

    rx_state_t state, state_next;

    logic                 tick, clr_div, sample_pt, deliver;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr_acc;
    logic                 perr_calc, ferr_calc, slot_free;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_1    <= rxd;
            sync_2    <= sync_1;
            line_prev <= sync_2;
        end
    end

    assign line = sync_2;
    assign fall = line_prev && !line;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clr_div),
        .tick (tick)
    );

    // START waits half a bit to land on the bit centre; later states a full bit.
    always_comb begin
        sample_pt = 1'b0;
        if (tick) begin
            if (state == ST_START) begin
                sample_pt = (tick_cnt == TICK_HALF);
            end else begin
                sample_pt = (tick_cnt == TICK_FULL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_div    = 1'b0;
        deliver    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_next = ST_START;
                    clr_div    = 1'b1;
                end
            end
            ST_START: begin
                if (sample_pt) begin
                    state_next = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_pt && bit_cnt == DATA_LAST) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_pt) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_pt && bit_cnt == STOP_LAST) begin
                    deliver    = 1'b1;
                    state_next = line ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (line) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick and bit counters restart on every state change; within DATA/STOP
    // they wrap at each sample so consecutive bits stay one bit period apart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (state_next != state) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (sample_pt) begin
                tick_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (state == ST_DATA && sample_pt) begin
                shreg <= {line, shreg[DATA_BITS-1:1]};
            end
            if (state == ST_PARITY && sample_pt) begin
                par_bit <= line;
            end
            if (state == ST_START) begin
                ferr_acc <= 1'b0;
            end else if (state == ST_STOP && sample_pt && !line) begin
                ferr_acc <= 1'b1;
            end
        end
    end

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == PAR_EVEN) begin
            perr_calc = ^shreg ^ par_bit;
        end else if (PARITY == PAR_ODD) begin
            perr_calc = ~(^shreg ^ par_bit);
        end
    end

    // Include the final stop sample, which is not yet in ferr_acc.
    assign ferr_calc = ferr_acc || !line;
    assign slot_free = !rx_valid || rx_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (deliver && slot_free) begin
                rx_data    <= shreg;
                parity_err <= perr_calc;
                frame_err  <= ferr_calc;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (deliver && !slot_free) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != ST_IDLE) && (state != ST_START);

endmodule
